// File: rtl/afg_pkg.sv
// Shared types and default widths for the AFG playback sequencer.
package afg_pkg;

  localparam int AFG_ADDR_W = 10;
  localparam int AFG_DATA_W = 12;
  localparam int AFG_DIV_W  = 16;
  localparam int AFG_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } afg_state_e;

endpackage

// File: rtl/afg_playback_ctrl_rate_div.sv
// Sample-rate divider: loadable down counter, tick when it reaches zero.
module afg_rate_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_lim,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  // Load on playback start, then count down and reload from the limit each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? i_lim : r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/afg_playback_ctrl.sv
// AFG playback sequencer: walks waveform RAM, paces reads, counts periods
// and registers the returned sample toward the output stage.
// Optional: AFG_TRIG_SYNC_EN adds 2-flop sync + rising-edge detect on start/stop.
module afg_playback_ctrl
  import afg_pkg::*;
#(
  parameter int ADDR_W = AFG_ADDR_W,
  parameter int DATA_W = AFG_DATA_W,
  parameter int DIV_W  = AFG_DIV_W,
  parameter int CNT_W  = AFG_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_burst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  logic w_start;
  logic w_stop;

`ifdef AFG_TRIG_SYNC_EN
  logic [2:0] r_start_sync;
  logic [2:0] r_stop_sync;

  // Two-flop synchronizer plus one history bit for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_sync <= '0;
      r_stop_sync  <= '0;
    end else begin
      r_start_sync <= {r_start_sync[1:0], start};
      r_stop_sync  <= {r_stop_sync[1:0], stop};
    end
  end

  assign w_start = r_start_sync[1] & ~r_start_sync[2];
  assign w_stop  = r_stop_sync[1]  & ~r_stop_sync[2];
`else
  assign w_start = start;
  assign w_stop  = stop;
`endif

  afg_state_e        r_state;
  logic [ADDR_W-1:0] r_len;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_burst;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_period;
  logic              r_mem_rd_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_go;
  logic              w_tick;
  logic [ADDR_W-1:0] w_rd_len;
  logic [CNT_W-1:0]  w_rd_burst;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [CNT_W-1:0]  w_rd_per;
  logic              w_wrap;
  logic [CNT_W-1:0]  w_per_inc;
  logic              w_last;

  assign w_go = (r_state == ST_IDLE) && w_start && !w_stop;

  afg_rate_div #(
    .DIV_W(DIV_W)
  ) u_rate_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_go),
    .i_load_val(cfg_div),
    .i_en      (r_state == ST_RUN),
    .i_lim     (r_div),
    .o_tick    (w_tick)
  );

  // The start cycle issues the first read from the live config, so the read
  // bookkeeping selects either live config (IDLE) or the shadow copies (RUN).
  always_comb begin
    w_rd_len   = r_len;
    w_rd_burst = r_burst;
    w_rd_addr  = r_addr;
    w_rd_per   = r_period;
    if (r_state == ST_IDLE) begin
      w_rd_len   = cfg_len;
      w_rd_burst = cfg_burst;
      w_rd_addr  = '0;
      w_rd_per   = '0;
    end
    w_wrap    = (w_rd_addr == w_rd_len);
    w_per_inc = (&w_rd_per) ? w_rd_per : w_rd_per + CNT_W'(1);
    w_last    = w_wrap && (w_rd_burst != '0) && (w_per_inc == w_rd_burst);
  end

  // Playback FSM with registered RAM strobe, sample pipeline and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_div       <= '0;
      r_burst     <= '0;
      r_addr      <= '0;
      r_period    <= '0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_rd_pend   <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_rd_en <= 1'b0;
      r_done      <= 1'b0;
      r_rd_pend   <= r_mem_rd_en;
      r_out_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_out_data <= mem_data;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_len       <= cfg_len;
            r_div       <= cfg_div;
            r_burst     <= cfg_burst;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= '0;
            r_addr      <= w_wrap ? '0 : ADDR_W'(1);
            r_period    <= w_wrap ? w_per_inc : '0;
            r_busy      <= 1'b1;
            r_state     <= w_last ? ST_DRAIN : ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_stop) begin
            r_state <= ST_DRAIN;
          end else if (w_tick) begin
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= r_addr;
            r_addr      <= w_wrap ? '0 : r_addr + ADDR_W'(1);
            if (w_wrap) begin
              r_period <= w_per_inc;
            end
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // The strobe is registered, so wait for it and its data beat to clear.
          if (!r_rd_pend && !r_mem_rd_en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_afg_playback_ctrl.sv
// Directed self-checking bench for afg_playback_ctrl (default build).
// Cycle k is the interval between clock edge k-1 and edge k; start is
// sampled at edge 0.
module tb_afg_playback_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 12;
  localparam int DIV_W  = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] cfg_len = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [CNT_W-1:0]  cfg_burst = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              done;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  afg_playback_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .cfg_len  (cfg_len),
    .cfg_div  (cfg_div),
    .cfg_burst(cfg_burst),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word(input int unsigned a);
    logic [31:0] t;
    t = a * 37 + 5;
    return t[DATA_W-1:0];
  endfunction

  // Waveform RAM: synchronous read, one-cycle latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= word(32'(mem_addr));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One playback. Reads land on cycles 1, 1+(div+1), ...; R reads total
  // (burst mode: (len+1)*burst, stop mode with div=0: stop_k). Data returns
  // two cycles after each read, done three cycles after the last read.
  task automatic run(input int unsigned len, input int unsigned div,
                     input int unsigned burst, input int unsigned stop_k,
                     input bit poke, input int unsigned ncyc);
    int unsigned R, L, j, m;
    bit rd_e, ov_e;
    logic [31:0] a_e, d_e;
    R = (stop_k != 0) ? (stop_k - 1) / (div + 1) + 1 : (len + 1) * burst;
    L = 1 + (R - 1) * (div + 1);
    @(negedge clk);
    cfg_len = ADDR_W'(len); cfg_div = DIV_W'(div); cfg_burst = CNT_W'(burst);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_len = 10'd5; cfg_div = 16'd3; cfg_burst = 16'd9;
    for (int unsigned k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      rd_e = 1'b0; a_e = '0; ov_e = 1'b0; d_e = '0;
      j = k - 1;
      if (j % (div + 1) == 0 && j / (div + 1) < R) begin
        rd_e = 1'b1;
        a_e  = (j / (div + 1)) % (len + 1);
      end
      if (k >= 3) begin
        j = k - 3;
        if (j % (div + 1) == 0 && j / (div + 1) < R) begin
          ov_e = 1'b1;
          m = (j / (div + 1)) % (len + 1);
          d_e = 32'(word(m));
        end
      end
      chk($sformatf("rd_en L%0d D%0d k%0d", len, div, k), 32'(mem_rd_en), 32'(rd_e));
      if (rd_e) chk($sformatf("addr L%0d D%0d k%0d", len, div, k), 32'(mem_addr), a_e);
      chk($sformatf("out_valid L%0d D%0d k%0d", len, div, k), 32'(out_valid), 32'(ov_e));
      if (ov_e) chk($sformatf("out_data L%0d D%0d k%0d", len, div, k), 32'(out_data), d_e);
      if (k > L + 2)
        chk($sformatf("hold L%0d D%0d k%0d", len, div, k), 32'(out_data),
            32'(word((R - 1) % (len + 1))));
      chk($sformatf("done L%0d D%0d k%0d", len, div, k), 32'(done), 32'(k == L + 3));
      chk($sformatf("busy L%0d D%0d k%0d", len, div, k), 32'(busy), 32'(k <= L + 2));
      start = poke && (k == 4);
      stop  = (stop_k != 0) && (k == stop_k);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rd_en", 32'(mem_rd_en), 0);
    chk("rst addr", 32'(mem_addr), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Burst of 2 periods of 4 samples, start poked again mid-run.
    run(3, 0, 2, 0, 1'b1, 14);
    // Divided rate, 2-sample single period.
    run(1, 2, 1, 0, 1'b0, 10);
    // Single-sample period, three periods.
    run(0, 0, 3, 0, 1'b0, 8);
    // Continuous play, stop in cycle 20.
    run(7, 0, 0, 20, 1'b0, 26);

    // start and stop together in IDLE: nothing happens.
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("ss rd_en k%0d", k), 32'(mem_rd_en), 0);
      chk($sformatf("ss busy k%0d", k), 32'(busy), 0);
    end

    // Reset mid-playback aborts at once, without done.
    @(negedge clk);
    cfg_len = 10'd7; cfg_div = 16'd1; cfg_burst = 16'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst rd_en", 32'(mem_rd_en), 0);
    chk("arst addr", 32'(mem_addr), 0);
    chk("arst out_data", 32'(out_data), 0);
    chk("arst out_valid", 32'(out_valid), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst done", 32'(done), 0);
    @(negedge clk);
    chk("arst done hold", 32'(done), 0);
    rst_n = 1'b1;
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("post rst rd_en k%0d", k), 32'(mem_rd_en), 0);
      chk($sformatf("post rst busy k%0d", k), 32'(busy), 0);
      chk($sformatf("post rst done k%0d", k), 32'(done), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
